// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with writeback bypass and a per-register RAW scoreboard.
// Destinations are tracked from issue to writeback, and stall is raised while a source is pending.
module wb_regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                flush,
    output logic                stall,
    output logic [ADDR_W+1:0]   pending_cnt,
    output logic                sb_err
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned SUM_W = ADDR_W + 2;

    logic [DATA_W-1:0] regs    [NREG];
    logic [1:0]        cnt     [NREG];
    logic [1:0]        cnt_nxt [NREG];
    logic [SUM_W-1:0]  sum_nxt;
    logic              err_set;
    logic              wb_hit;
    logic              issue_fire;
    logic              pend1;
    logic              pend2;

    assign wb_hit     = wb_valid && (wb_rd != '0);
    assign issue_fire = issue_valid && !stall && (issue_rd != '0);

    // Reads with writeback bypass; register 0 always reads zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0)
            rs1_data = (wb_valid && wb_rd == rs1_addr) ? wb_data : regs[rs1_addr];
        if (rs2_addr != '0)
            rs2_data = (wb_valid && wb_rd == rs2_addr) ? wb_data : regs[rs2_addr];
    end

    // A last outstanding write arriving this cycle is covered by the bypass, so it does not stall.
    always_comb begin
        pend1 = (rs1_addr != '0) && (cnt[rs1_addr] != 2'd0)
                && !(cnt[rs1_addr] == 2'd1 && wb_hit && wb_rd == rs1_addr);
        pend2 = (rs2_addr != '0) && (cnt[rs2_addr] != 2'd0)
                && !(cnt[rs2_addr] == 2'd1 && wb_hit && wb_rd == rs2_addr);
        stall = pend1 || pend2;
    end

    // Next counter values, saturation errors and the in-flight total.
    always_comb begin
        err_set    = 1'b0;
        sum_nxt    = '0;
        cnt_nxt[0] = 2'd0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (flush) begin
                cnt_nxt[r] = 2'd0;
            end else if (issue_fire && issue_rd == ADDR_W'(r)
                         && !(wb_hit && wb_rd == ADDR_W'(r))) begin
                if (cnt[r] == 2'd3) err_set = 1'b1;
                else                cnt_nxt[r] = cnt[r] + 2'd1;
            end else if (wb_hit && wb_rd == ADDR_W'(r)
                         && !(issue_fire && issue_rd == ADDR_W'(r))) begin
                if (cnt[r] == 2'd0) err_set = 1'b1;
                else                cnt_nxt[r] = cnt[r] - 2'd1;
            end
            sum_nxt = sum_nxt + SUM_W'(cnt_nxt[r]);
        end
    end

    // Register storage; flush does not cancel the writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
        end else if (wb_hit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Scoreboard state, total and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) cnt[r] <= 2'd0;
            pending_cnt <= '0;
            sb_err      <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            pending_cnt <= sum_nxt;
            if (err_set) sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Scoreboard bench for wb_regfile_scoreboard: expectations are queued as stimulus is
// driven and popped against the DUT outputs once they are valid.
module tb_wb_regfile_scoreboard;

    localparam int K_RS1   = 0;
    localparam int K_RS2   = 1;
    localparam int K_STALL = 2;
    localparam int K_PCNT  = 3;
    localparam int K_ERR   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        issue_valid, wb_valid, flush, stall, sb_err;
    logic [6:0]  pending_cnt;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_err;
    int          m_pcnt;

    wb_regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall(stall),
        .pending_cnt(pending_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RS1:   return rs1_data;
            K_RS2:   return rs2_data;
            K_STALL: return {31'b0, stall};
            K_PCNT:  return 32'(pending_cnt);
            default: return {31'b0, sb_err};
        endcase
    endfunction

    task automatic push(input int kind, input string name, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drain_q();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, observe(e.kind), e.val);
        end
    endtask

    task automatic spot(input int kind, input string name, input logic [31:0] val);
        push(kind, name, val);
        drain_q();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err  = 1'b0;
        m_pcnt = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic wv,
                                            input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (wv && wrd == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a, input logic wv, input logic [4:0] wrd);
        if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
        return !(m_cnt[a] == 1 && wv && wrd != 5'd0 && wrd == a);
    endfunction

    // One clock of stimulus: check decode-side outputs before the edge, registered ones after.
    task automatic cycle(input string lbl, input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic fl);
        logic e_stall, fire, hit;
        int   sum;
        rs1_addr = a1; rs2_addr = a2;
        issue_valid = iv; issue_rd = ird;
        wb_valid = wv; wb_rd = wrd; wb_data = wd; flush = fl;
        e_stall = exp_pend(a1, wv, wrd) || exp_pend(a2, wv, wrd);
        push(K_RS1,   {lbl, ".rs1"},   exp_rd(a1, wv, wrd, wd));
        push(K_RS2,   {lbl, ".rs2"},   exp_rd(a2, wv, wrd, wd));
        push(K_STALL, {lbl, ".stall"}, {31'b0, e_stall});
        #1;
        drain_q();
        @(posedge clk);
        fire = iv && !e_stall && ird != 5'd0;
        hit  = wv && wrd != 5'd0;
        if (hit) m_regs[wrd] = wd;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            if (fire && !(hit && wrd == ird)) begin
                if (m_cnt[ird] == 3) m_err = 1'b1;
                else m_cnt[ird]++;
            end
            if (hit && !(fire && ird == wrd)) begin
                if (m_cnt[wrd] == 0) m_err = 1'b1;
                else m_cnt[wrd]--;
            end
        end
        sum = 0;
        for (int i = 0; i < 32; i++) sum += m_cnt[i];
        m_pcnt = sum;
        #1;
        push(K_PCNT, {lbl, ".pcnt"}, 32'(m_pcnt));
        push(K_ERR,  {lbl, ".err"},  {31'b0, m_err});
        drain_q();
    endtask

    task automatic rd2(input string lbl, input logic [4:0] a1, input logic [4:0] a2);
        cycle(lbl, a1, a2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic iss(input string lbl, input logic [4:0] rd);
        cycle(lbl, 5'd0, 5'd0, 1'b1, rd, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic wb(input string lbl, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] rd, input logic [31:0] d);
        cycle(lbl, a1, a2, 1'b0, 5'd0, 1'b1, rd, d, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        spot(K_PCNT,  "reset.pcnt",  32'h0);
        spot(K_ERR,   "reset.err",   32'h0);
        spot(K_STALL, "reset.stall", 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) rd2("sweep", 5'(i), 5'(31 - i));

        wb("w_r0", 5'd0, 5'd0, 5'd0, 32'hDEADBEEF);
        rd2("rd_r0", 5'd0, 5'd0);
        spot(K_RS1, "r0_zero", 32'h0);

        // Single producer on r5, dependent held until writeback arrives.
        iss("iss5", 5'd5);
        for (int i = 0; i < 3; i++) rd2("wait5", 5'd5, 5'd0);
        wb("byp5", 5'd5, 5'd0, 5'd5, 32'h12345678);
        rd2("rd5", 5'd5, 5'd0);
        spot(K_RS1,  "r5_stored", 32'h12345678);
        spot(K_PCNT, "r5_pcnt",   32'h0);

        // Three producers on r7, drained one at a time.
        for (int i = 0; i < 3; i++) iss("iss7", 5'd7);
        spot(K_PCNT, "r7_full", 32'd3);
        wb("wb7a", 5'd0, 5'd7, 5'd7, 32'h71);
        wb("wb7b", 5'd0, 5'd7, 5'd7, 32'h72);
        wb("wb7c", 5'd0, 5'd7, 5'd7, 32'h73);
        rd2("rd7", 5'd0, 5'd7);
        spot(K_STALL, "r7_free", 32'h0);

        // Issue and writeback to r9 on the same edge cancel out.
        iss("iss9", 5'd9);
        cycle("iw9", 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0);
        spot(K_PCNT, "r9_same", 32'd1);
        wb("wb9", 5'd0, 5'd0, 5'd9, 32'h9A);

        // Overflow on r3, then underflow on r4.
        for (int i = 0; i < 4; i++) iss("iss3", 5'd3);
        spot(K_ERR,  "ovf_err",  32'h1);
        spot(K_PCNT, "ovf_pcnt", 32'd3);
        wb("wb4", 5'd0, 5'd0, 5'd4, 32'h44);
        rd2("rd4", 5'd4, 5'd0);
        spot(K_RS1, "r4_written", 32'h44);
        for (int i = 0; i < 3; i++) wb("wb3", 5'd3, 5'd0, 5'd3, 32'(32'h30 + i));

        // Flush with a coincident writeback.
        iss("iss2", 5'd2);
        iss("iss6", 5'd6);
        cycle("flush", 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'hA5, 1'b1);
        spot(K_PCNT, "flush_pcnt", 32'h0);
        rd2("post_flush", 5'd2, 5'd6);
        spot(K_STALL, "flush_stall", 32'h0);
        spot(K_RS2,   "flush_r6",    32'hA5);

        // Asynchronous reset mid-stream; a writeback during reset is lost.
        iss("iss8", 5'd8);
        rs1_addr = 5'd8; rs2_addr = 5'd6;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        spot(K_PCNT,  "arst_pcnt",  32'h0);
        spot(K_ERR,   "arst_err",   32'h0);
        spot(K_STALL, "arst_stall", 32'h0);
        spot(K_RS2,   "arst_r6",    32'h0);
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h77;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        rst = 1'b0;
        rd2("after_rst", 5'd8, 5'd6);
        spot(K_RS2, "lost_wb", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
